// File: rtl/wb_regfile.sv
// Write-back stage: selects the value to retire, commits it into the 16x32 register
// file and flag register, and serves two bypassed read ports plus a retired counter.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int FLAG_W = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ENABLE,
   input  logic [ADDR_W-1:0] in_WC,
   input  logic [DATA_W-1:0] in_PC,
   input  logic [DATA_W-1:0] in_PR,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [FLAG_W-1:0] in_flags,
   input  logic [1:0]        in_S_MXRB,
   input  logic              in_W_RB,
   input  logic [2:0]        in_W_RF,
   input  logic [ADDR_W-1:0] in_RA,
   input  logic [ADDR_W-1:0] in_RB,
   output logic [DATA_W-1:0] out_DA,
   output logic [DATA_W-1:0] out_DB,
   output logic [FLAG_W-1:0] out_flags,
   output logic [DATA_W-1:0] out_wb_data,
   output logic [DATA_W-1:0] out_retired
);

   localparam int REG_N = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regFile [REG_N];
   logic [FLAG_W-1:0] r_flags;
   logic [DATA_W-1:0] r_retired;

   logic [DATA_W-1:0] w_wbData;
   logic              w_regWrite;
   logic              w_bypassA;
   logic              w_bypassB;

   // The reserved select 11 falls back to the ALU result so the output is never X.
   always_comb begin
      w_wbData = in_alu_res;
      case (in_S_MXRB)
         2'b01:   w_wbData = in_PR;
         2'b10:   w_wbData = in_PC;
         default: w_wbData = in_alu_res;
      endcase
   end

   assign w_regWrite = ENABLE & in_W_RB;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < REG_N; i++) begin
            r_regFile[i] <= '0;
         end
      end else if (w_regWrite) begin
         r_regFile[in_WC] <= w_wbData;
      end
   end

   // Flag layout {V,C,Z,N}: group 0 owns N and Z, group 1 owns C, group 2 owns V.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_flags <= '0;
      end else if (ENABLE) begin
         if (in_W_RF[0]) begin
            r_flags[1:0] <= in_flags[1:0];
         end
         if (in_W_RF[1]) begin
            r_flags[2] <= in_flags[2];
         end
         if (in_W_RF[2]) begin
            r_flags[3] <= in_flags[3];
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_retired <= '0;
      end else if (ENABLE) begin
         r_retired <= r_retired + DATA_W'(1);
      end
   end

   assign w_bypassA = w_regWrite & (in_WC == in_RA);
   assign w_bypassB = w_regWrite & (in_WC == in_RB);

   assign out_DA      = w_bypassA ? w_wbData : r_regFile[in_RA];
   assign out_DB      = w_bypassB ? w_wbData : r_regFile[in_RB];
   assign out_flags   = r_flags;
   assign out_wb_data = w_wbData;
   assign out_retired = r_retired;

endmodule
